oled_spi_sink: RTL and testbench

Receive-side counterpart of the OLED SPI link. The block watches the four-wire SPI bus produced by `oled_controller`: `spi_cs`, `spi_clk`, `spi_mosi` and `oled_dc`. It deserialises each byte and tags it with its D/C bit, then queues it in a small first-word-fall-through FIFO for a consumer in the `clk` domain. It serves as the display-side model in simulation and as a loopback/monitor on hardware, so transmitted streams such as "hello" (0x68 0x65 0x6C 0x6C 0x6F) can be checked byte by byte.

---
 rtl/oled_spi_sink_if.sv | 28 ++
 rtl/oled_spi_sink.sv | 135 +++++++++++++
 tb/tb_oled_spi_sink.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/oled_spi_sink_if.sv
// Bus between the OLED SPI sink and its environment: the four-wire SPI link
// coming in, and the FIFO read port plus status flags going out.
interface oled_spi_sink_if #(
  parameter int FIFO_DEPTH = 4
);
  logic                          spi_cs;
  logic                          spi_clk;
  logic                          spi_mosi;
  logic                          oled_dc;
  logic                          rd_en;
  logic                          clear_errors;
  logic [7:0]                    rd_data;
  logic                          rd_dc;
  logic                          rd_valid;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;
  logic                          overflow;
  logic                          frame_error;

  modport master (
    output spi_cs, spi_clk, spi_mosi, oled_dc, rd_en, clear_errors,
    input  rd_data, rd_dc, rd_valid, fifo_count, overflow, frame_error
  );

  modport slave (
    input  spi_cs, spi_clk, spi_mosi, oled_dc, rd_en, clear_errors,
    output rd_data, rd_dc, rd_valid, fifo_count, overflow, frame_error
  );
endinterface

// File: rtl/oled_spi_sink.sv
// SPI mode-0 receiver for the OLED link: synchronises the bus into clk,
// deserialises D/C-tagged bytes and queues them in a small FWFT FIFO.
module oled_spi_sink #(
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input logic             clk,
  input logic             reset,
  oled_spi_sink_if.slave  bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  // Synchroniser lane order {dc, mosi, sclk, cs}; idle bus is CS high, SCLK low.
  localparam logic [3:0] SYNC_RST = 4'b0001;

  typedef enum logic {IDLE, SHIFT} state_e;

  logic [SYNC_STAGES-1:0][3:0] sync_q, sync_d;
  logic                        sclk_prev_q, sclk_prev_d;
  state_e                      state_q, state_d;
  logic [2:0]                  cnt_q, cnt_d;
  logic [7:0]                  shift_q, shift_d;
  logic [FIFO_DEPTH-1:0][8:0]  mem_q, mem_d;
  logic [AW-1:0]               wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]               count_q, count_d;
  logic                        overflow_q, overflow_d;
  logic                        frame_error_q, frame_error_d;

  logic cs_s, sclk_s, mosi_s, dc_s, sclk_rise;
  logic shift_en, byte_done, abort;
  logic push, pop, full, ovf_evt;
  logic [8:0] wr_word;

  assign cs_s      = sync_q[SYNC_STAGES-1][0];
  assign sclk_s    = sync_q[SYNC_STAGES-1][1];
  assign mosi_s    = sync_q[SYNC_STAGES-1][2];
  assign dc_s      = sync_q[SYNC_STAGES-1][3];
  assign sclk_rise = sclk_s & ~sclk_prev_q;

  always_comb begin
    sync_d      = {sync_q[SYNC_STAGES-2:0],
                   {bus.oled_dc, bus.spi_mosi, bus.spi_clk, bus.spi_cs}};
    sclk_prev_d = sclk_s;
  end

  // Receiver FSM: state register / next state / outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!cs_s) state_d = SHIFT;
      SHIFT:   if (cs_s)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    shift_en  = (state_q == SHIFT) && !cs_s && sclk_rise;
    byte_done = shift_en && (cnt_q == 3'd7);
    abort     = (state_q == SHIFT) && cs_s && (cnt_q != 3'd0);
  end

  always_comb begin
    cnt_d   = cnt_q;
    shift_d = shift_q;
    if (state_q == IDLE || cs_s) begin
      cnt_d = 3'd0;
    end else if (shift_en) begin
      cnt_d   = cnt_q + 3'd1;
      shift_d = {shift_q[6:0], mosi_s};
    end
  end

  assign wr_word = {dc_s, shift_q[6:0], mosi_s};

  // FIFO: a pop frees the slot the same cycle, so full + pop still accepts a write.
  always_comb begin
    full    = (count_q == CW'(FIFO_DEPTH));
    pop     = bus.rd_en && (count_q != '0);
    push    = byte_done && (!full || pop);
    ovf_evt = byte_done && full && !pop;
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    if (push) begin
      mem_d[wptr_q] = wr_word;
      wptr_d        = wptr_q + AW'(1);
    end
    if (pop) rptr_d = rptr_q + AW'(1);
    count_d = count_q + CW'(push) - CW'(pop);
  end

  // Error events win over a coincident clear.
  always_comb begin
    overflow_d    = ovf_evt ? 1'b1 : (bus.clear_errors ? 1'b0 : overflow_q);
    frame_error_d = abort   ? 1'b1 : (bus.clear_errors ? 1'b0 : frame_error_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q        <= {SYNC_STAGES{SYNC_RST}};
      sclk_prev_q   <= 1'b0;
      cnt_q         <= 3'd0;
      shift_q       <= 8'd0;
      mem_q         <= '0;
      wptr_q        <= '0;
      rptr_q        <= '0;
      count_q       <= '0;
      overflow_q    <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      sync_q        <= sync_d;
      sclk_prev_q   <= sclk_prev_d;
      cnt_q         <= cnt_d;
      shift_q       <= shift_d;
      mem_q         <= mem_d;
      wptr_q        <= wptr_d;
      rptr_q        <= rptr_d;
      count_q       <= count_d;
      overflow_q    <= overflow_d;
      frame_error_q <= frame_error_d;
    end
  end

  assign bus.rd_valid    = (count_q != '0);
  assign bus.rd_data     = bus.rd_valid ? mem_q[rptr_q][7:0] : 8'd0;
  assign bus.rd_dc       = bus.rd_valid ? mem_q[rptr_q][8]   : 1'b0;
  assign bus.fifo_count  = count_q;
  assign bus.overflow    = overflow_q;
  assign bus.frame_error = frame_error_q;
endmodule

// File: tb/tb_oled_spi_sink.sv
// Directed bench for oled_spi_sink: bit-bangs SPI frames with SCLK phases of
// four clk periods and checks the FIFO contents and flags against fixed values.
module tb_oled_spi_sink;
  localparam int FD = 4;
  localparam int SS = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  oled_spi_sink_if #(.FIFO_DEPTH(FD)) bus();

  oled_spi_sink #(.FIFO_DEPTH(FD), .SYNC_STAGES(SS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Advance n clk edges and settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cs_low();
    bus.spi_cs = 1'b0;
    tick(4);
  endtask

  task automatic cs_high();
    bus.spi_cs = 1'b1;
    tick(6);
  endtask

  task automatic clr_pulse();
    bus.clear_errors = 1'b1;
    tick(1);
    bus.clear_errors = 1'b0;
  endtask

  // Shift the top nbits of b MSB first. mode 1: check rd_valid latency on the
  // last bit; mode 2: hold rd_en across the edge that writes the last bit.
  task automatic spi_bits(input logic [7:0] b, input logic dc, input int nbits, input int mode);
    for (int i = 7; i > 7 - nbits; i--) begin
      bus.spi_mosi = b[i];
      bus.oled_dc  = dc;
      tick(4);
      bus.spi_clk = 1'b1;
      if (i == 0 && mode == 1) begin
        tick(2);
        chk("lat_edge2_valid", bus.rd_valid, 0);
        tick(1);
        chk("lat_edge3_valid", bus.rd_valid, 1);
        tick(1);
      end else if (i == 0 && mode == 2) begin
        tick(2);
        bus.rd_en = 1'b1;
        tick(1);
        bus.rd_en = 1'b0;
        tick(1);
      end else begin
        tick(4);
      end
      bus.spi_clk = 1'b0;
    end
  endtask

  // Check head {valid, dc, data}, then pop it.
  task automatic pop_chk(input string tag, input logic [7:0] d, input logic dc);
    chk(tag, {bus.rd_valid, bus.rd_dc, bus.rd_data}, {1'b1, dc, d});
    bus.rd_en = 1'b1;
    tick(1);
    bus.rd_en = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_data"},  bus.rd_data,     0);
    chk({tag, "_dc"},    bus.rd_dc,       0);
    chk({tag, "_valid"}, bus.rd_valid,    0);
    chk({tag, "_count"}, bus.fifo_count,  0);
    chk({tag, "_ovf"},   bus.overflow,    0);
    chk({tag, "_ferr"},  bus.frame_error, 0);
  endtask

  initial begin
    logic [7:0] hello [5];
    hello = '{8'h68, 8'h65, 8'h6C, 8'h6C, 8'h6F};

    reset = 1'b1;
    bus.spi_cs = 1'b1;
    bus.spi_clk = 1'b0;
    bus.spi_mosi = 1'b0;
    bus.oled_dc = 1'b0;
    bus.rd_en = 1'b0;
    bus.clear_errors = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(2);
    chk_zero("reset");

    // Single byte with latency check
    cs_low();
    spi_bits(8'h68, 1'b1, 8, 1);
    cs_high();
    chk("t1_count", bus.fifo_count, 1);
    pop_chk("t1_head", 8'h68, 1'b1);
    chk("t1_count_empty", bus.fifo_count, 0);
    chk("t1_data_empty", bus.rd_data, 0);

    // Five bytes in one frame into a 4-deep FIFO
    cs_low();
    for (int i = 0; i < 5; i++) spi_bits(hello[i], 1'b1, 8, 0);
    cs_high();
    chk("t2_count_full", bus.fifo_count, 4);
    chk("t2_ovf_set", bus.overflow, 1);
    for (int i = 0; i < 4; i++) pop_chk("t2_head", hello[i], 1'b1);
    chk("t2_count_empty", bus.fifo_count, 0);
    chk("t2_ovf_sticky", bus.overflow, 1);
    clr_pulse();
    chk("t2_ovf_cleared", bus.overflow, 0);
    bus.rd_en = 1'b1;
    tick(2);
    bus.rd_en = 1'b0;
    chk("t2_pop_empty_count", bus.fifo_count, 0);
    chk("t2_pop_empty_valid", bus.rd_valid, 0);

    // Command / data tagging
    cs_low();
    spi_bits(8'hAF, 1'b0, 8, 0);
    spi_bits(8'h20, 1'b1, 8, 0);
    cs_high();
    chk("t3_count", bus.fifo_count, 2);
    pop_chk("t3_cmd", 8'hAF, 1'b0);
    pop_chk("t3_dat", 8'h20, 1'b1);

    // Frame error, recovery, and clear coinciding with a new abort
    cs_low();
    spi_bits(8'hB7, 1'b1, 5, 0);
    cs_high();
    chk("t4_no_entry", bus.fifo_count, 0);
    chk("t4_ferr_set", bus.frame_error, 1);
    clr_pulse();
    chk("t4_ferr_cleared", bus.frame_error, 0);
    cs_low();
    spi_bits(8'h55, 1'b1, 8, 0);
    cs_high();
    chk("t4_ferr_clean", bus.frame_error, 0);
    pop_chk("t4_head", 8'h55, 1'b1);
    cs_low();
    spi_bits(8'hFF, 1'b0, 3, 0);
    bus.spi_cs = 1'b1;
    tick(2);
    bus.clear_errors = 1'b1;   // lands on the edge that sees synced CS rise
    tick(1);
    bus.clear_errors = 1'b0;
    chk("t4_ferr_event_wins", bus.frame_error, 1);
    tick(3);

    // Full FIFO with pop on the write edge
    cs_low();
    spi_bits(8'h11, 1'b1, 8, 0);
    spi_bits(8'h22, 1'b1, 8, 0);
    spi_bits(8'h33, 1'b1, 8, 0);
    spi_bits(8'h44, 1'b1, 8, 0);
    chk("t5_count_full", bus.fifo_count, 4);
    spi_bits(8'hA5, 1'b1, 8, 2);
    cs_high();
    chk("t5_count_kept", bus.fifo_count, 4);
    chk("t5_no_ovf", bus.overflow, 0);
    pop_chk("t5_head", 8'h22, 1'b1);
    pop_chk("t5_head", 8'h33, 1'b1);
    pop_chk("t5_head", 8'h44, 1'b1);
    pop_chk("t5_last", 8'hA5, 1'b1);
    chk("t5_count_empty", bus.fifo_count, 0);

    // Reset mid-byte with entries queued
    cs_low();
    spi_bits(8'h01, 1'b1, 8, 0);
    spi_bits(8'h02, 1'b1, 8, 0);
    chk("t6_count_pre", bus.fifo_count, 2);
    spi_bits(8'hC3, 1'b1, 3, 0);
    reset = 1'b1;
    #1;
    chk_zero("t6_reset");
    tick(2);
    reset = 1'b0;
    spi_bits({5'b00011, 3'b000}, 1'b1, 5, 0);
    cs_high();
    chk("t6_no_entry", bus.fifo_count, 0);
    clr_pulse();
    cs_low();
    spi_bits(8'h3C, 1'b1, 8, 0);
    cs_high();
    chk("t6_count", bus.fifo_count, 1);
    chk("t6_ferr", bus.frame_error, 0);
    chk("t6_ovf", bus.overflow, 0);
    pop_chk("t6_head", 8'h3C, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
